// File: rtl/uart_pkg.sv
// Shared definitions for the UART AXI-lite read-side slave: register
// offsets, RXDATA/STATUS field positions, AXI response codes, FSM states
// and the RX FIFO entry layout.
package uart_pkg;

   // Register offsets decoded from araddr[3:0]
   localparam logic [3:0] REG_RXDATA = 4'h0;
   localparam logic [3:0] REG_STATUS = 4'h4;

   // RXDATA field positions
   localparam int unsigned RX_VALID_BIT = 8;
   localparam int unsigned RX_FERR_BIT  = 9;

   // STATUS field positions
   localparam int unsigned STAT_NOT_EMPTY_BIT = 0;
   localparam int unsigned STAT_FULL_BIT      = 1;
   localparam int unsigned STAT_OVF_BIT       = 2;
   localparam int unsigned STAT_FERR_BIT      = 3;
   localparam int unsigned STAT_COUNT_LSB     = 8;
   localparam int unsigned STAT_COUNT_W       = 8;

   // AXI response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Read FSM states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } rd_state_e;

   // RX FIFO entry: {frame_err, byte}
   typedef struct packed {
      logic       frame_err;
      logic [7:0] data;
   } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous RX FIFO for received UART bytes.
// Ports:
//   clk, rst        - clock, synchronous active-high reset (flushes pointers)
//   push, din       - write request and entry
//   pop             - read request (ignored when empty)
//   head_c          - entry at the read pointer (combinational view)
//   full, empty     - registered flags
//   count           - registered occupancy, $clog2(DEPTH)+1 bits
//   push_ok_c       - push accepted this cycle (not full, or full with pop)
//   empty_nxt_c     - FIFO will be empty after this edge
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  rx_entry_t              din,
   input  logic                   pop,
   output rx_entry_t              head_c,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   push_ok_c,
   output logic                   empty_nxt_c
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   rx_entry_t         mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic              pop_ok;
   logic [CW-1:0]     count_nxt;

   // A full FIFO still accepts a push when the head is popped in the same cycle
   always_comb begin
      pop_ok      = pop & ~empty;
      push_ok_c   = push & (~full | pop_ok);
      count_nxt   = count + CW'(push_ok_c) - CW'(pop_ok);
      empty_nxt_c = (count_nxt == '0);
      head_c      = mem[rd_ptr];
   end

   // Storage, no reset needed
   always_ff @(posedge clk) begin
      if (push_ok_c) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap modulo DEPTH (power of two)
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok_c) wr_ptr <= wr_ptr + PW'(1);
         if (pop_ok)    rd_ptr <= rd_ptr + PW'(1);
         count <= count_nxt;
         full  <= (count_nxt == CW'(DEPTH));
         empty <= empty_nxt_c;
      end
   end

endmodule

// File: rtl/axi_lite_uart_rd_slave.sv
// AXI-lite read-channel slave of the UART peripheral. Buffers received bytes
// in an RX FIFO, serves RXDATA (pop) and STATUS (clear sticky) reads, and
// drives a registered interrupt.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   s_axi_ar*/s_axi_r*          - AXI-lite AR and R channels
//   rx_byte_i/rx_valid_i/
//   rx_frame_err_i              - byte stream from the UART receiver
//   irq_en_i                    - [0] not-empty enable, [1] overflow enable
//   uart_irq                    - registered interrupt
// Build option: define UART_RD_SLVERR_EN to answer unmapped offsets and
// empty RXDATA reads with SLVERR instead of OKAY.
module axi_lite_uart_rd_slave
   import uart_pkg::*;
#(
   parameter int unsigned AXI_ADDR_WIDTH = 32,
   parameter int unsigned AXI_DATA_WIDTH = 32,
   parameter int unsigned AXI_RESP_WIDTH = 2,
   parameter int unsigned RX_FIFO_DEPTH  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
   output logic [AXI_RESP_WIDTH-1:0] s_axi_rresp,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   input  logic [7:0]                rx_byte_i,
   input  logic                      rx_valid_i,
   input  logic                      rx_frame_err_i,
   input  logic [1:0]                irq_en_i,
   output logic                      uart_irq
);

   localparam int unsigned CNT_W = $clog2(RX_FIFO_DEPTH) + 1;

`ifdef UART_RD_SLVERR_EN
   localparam logic [1:0] ERR_RESP = RESP_SLVERR;
`else
   localparam logic [1:0] ERR_RESP = RESP_OKAY;
`endif

   rd_state_e                 state_q, state_d;
   logic                      arready_d, rvalid_d;
   logic [AXI_DATA_WIDTH-1:0] rdata_d;
   logic [AXI_RESP_WIDTH-1:0] rresp_d;
   logic                      ar_hs_c;

   rx_entry_t                 fifo_din;
   rx_entry_t                 fifo_head_c;
   logic                      fifo_full, fifo_empty;
   logic [CNT_W-1:0]          fifo_count;
   logic                      fifo_push_ok_c, fifo_empty_nxt_c;
   logic                      pop_c, clr_c;

   logic                      ovf_q, ferr_q, ovf_d, ferr_d;
   logic                      irq_d;

   logic [15:0]               stat16_c, rx16_c;
   logic [AXI_DATA_WIDTH-1:0] rd_word_c;
   logic [1:0]                rd_resp_c;
   logic                      rd_pop_c, rd_clr_c;
   logic [3:0]                off_c;
   logic                      unused_addr_c;

   assign unused_addr_c = ^s_axi_araddr[AXI_ADDR_WIDTH-1:4];
   assign ar_hs_c       = s_axi_arready & s_axi_arvalid;
   assign fifo_din      = '{frame_err: rx_frame_err_i, data: rx_byte_i};

   uart_rx_fifo #(
      .DEPTH (RX_FIFO_DEPTH)
   ) u_rx_fifo (
      .clk         (clk),
      .rst         (rst),
      .push        (rx_valid_i),
      .din         (fifo_din),
      .pop         (pop_c),
      .head_c      (fifo_head_c),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .count       (fifo_count),
      .push_ok_c   (fifo_push_ok_c),
      .empty_nxt_c (fifo_empty_nxt_c)
   );

   // Offset decode; reflects FIFO/sticky state before any same-cycle push
   always_comb begin
      off_c     = s_axi_araddr[3:0];
      rd_word_c = '0;
      rd_resp_c = RESP_OKAY;
      rd_pop_c  = 1'b0;
      rd_clr_c  = 1'b0;

      stat16_c = '0;
      stat16_c[STAT_NOT_EMPTY_BIT] = ~fifo_empty;
      stat16_c[STAT_FULL_BIT]      = fifo_full;
      stat16_c[STAT_OVF_BIT]       = ovf_q;
      stat16_c[STAT_FERR_BIT]      = ferr_q;
      stat16_c[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);

      rx16_c = '0;
      rx16_c[7:0]         = fifo_head_c.data;
      rx16_c[RX_VALID_BIT] = 1'b1;
      rx16_c[RX_FERR_BIT]  = fifo_head_c.frame_err;

      if (off_c == REG_RXDATA) begin
         if (!fifo_empty) begin
            rd_word_c = AXI_DATA_WIDTH'(rx16_c);
            rd_pop_c  = 1'b1;
         end else begin
            rd_resp_c = ERR_RESP;
         end
      end else if (off_c == REG_STATUS) begin
         rd_word_c = AXI_DATA_WIDTH'(stat16_c);
         rd_clr_c  = 1'b1;
      end else begin
         rd_resp_c = ERR_RESP;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (ar_hs_c)      state_d = ST_RESP;
         ST_RESP: if (s_axi_rready) state_d = ST_IDLE;
         default:                   state_d = ST_IDLE;
      endcase
   end

   // FSM outputs (next values of the registered AXI outputs) and side effects
   always_comb begin
      arready_d = (state_d == ST_IDLE);
      rvalid_d  = (state_d == ST_RESP);
      rdata_d   = s_axi_rdata;
      rresp_d   = s_axi_rresp;
      pop_c     = 1'b0;
      clr_c     = 1'b0;
      if (state_q == ST_IDLE && ar_hs_c) begin
         rdata_d = rd_word_c;
         rresp_d = AXI_RESP_WIDTH'(rd_resp_c);
         pop_c   = rd_pop_c;
         clr_c   = rd_clr_c;
      end
   end

   // Sticky flags: a same-cycle set beats the STATUS-read clear
   always_comb begin
      ovf_d  = (ovf_q  & ~clr_c) | (rx_valid_i & ~fifo_push_ok_c);
      ferr_d = (ferr_q & ~clr_c) | (fifo_push_ok_c & rx_frame_err_i);
      irq_d  = (irq_en_i[0] & ~fifo_empty_nxt_c) | (irq_en_i[1] & ovf_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rdata   <= '0;
         s_axi_rresp   <= '0;
         ovf_q         <= 1'b0;
         ferr_q        <= 1'b0;
         uart_irq      <= 1'b0;
      end else begin
         s_axi_arready <= arready_d;
         s_axi_rvalid  <= rvalid_d;
         s_axi_rdata   <= rdata_d;
         s_axi_rresp   <= rresp_d;
         ovf_q         <= ovf_d;
         ferr_q        <= ferr_d;
         uart_irq      <= irq_d;
      end
   end

endmodule

// File: tb/tb_axi_lite_uart_rd_slave.sv
// Self-checking bench for axi_lite_uart_rd_slave: a behavioral model of the
// FIFO and sticky flags predicts each read; predictions are queued at AR
// acceptance and compared when the R beat appears.
module tb_axi_lite_uart_rd_slave;

   localparam int unsigned DEPTH = 16;

`ifdef UART_RD_SLVERR_EN
   localparam logic [1:0] EXP_ERR = 2'b10;
`else
   localparam logic [1:0] EXP_ERR = 2'b00;
`endif

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        rx_ferr;
   logic [1:0]  irq_en;
   logic        irq;

   int          checks   = 0;
   int          failures = 0;

   exp_t        exp_q[$];
   logic [8:0]  mq[$];
   bit          m_ovf;
   bit          m_ferr;

   logic [31:0] got;
   logic        got_irq;

   always #5 clk = ~clk;

   axi_lite_uart_rd_slave dut (
      .clk            (clk),
      .rst            (rst),
      .s_axi_araddr   (araddr),
      .s_axi_arvalid  (arvalid),
      .s_axi_arready  (arready),
      .s_axi_rdata    (rdata),
      .s_axi_rresp    (rresp),
      .s_axi_rvalid   (rvalid),
      .s_axi_rready   (rready),
      .rx_byte_i      (rx_byte),
      .rx_valid_i     (rx_valid),
      .rx_frame_err_i (rx_ferr),
      .irq_en_i       (irq_en),
      .uart_irq       (irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic void model_push(input logic [7:0] b, input bit f);
      if (mq.size() < DEPTH) begin
         mq.push_back({f, b});
         if (f) m_ferr = 1'b1;
      end else begin
         m_ovf = 1'b1;
      end
   endfunction

   // Predict a read and apply its pop/clear to the model
   function automatic exp_t model_read(input logic [31:0] addr);
      exp_t       e;
      logic [3:0] off;
      logic [8:0] ent;
      int         cnt;
      off = addr[3:0];
      e.data = '0;
      e.resp = 2'b00;
      if (off == 4'h0) begin
         if (mq.size() > 0) begin
            ent = mq.pop_front();
            e.data = {22'd0, ent[8], 1'b1, ent[7:0]};
         end else begin
            e.resp = EXP_ERR;
         end
      end else if (off == 4'h4) begin
         cnt = mq.size();
         e.data = {16'd0, 8'(cnt), 4'd0, m_ferr, m_ovf,
                   (cnt == DEPTH), (cnt != 0)};
         m_ovf  = 1'b0;
         m_ferr = 1'b0;
      end else begin
         e.resp = EXP_ERR;
      end
      return e;
   endfunction

   task automatic push_byte(input logic [7:0] b, input bit f);
      @(negedge clk);
      rx_byte = b; rx_valid = 1'b1; rx_ferr = f;
      model_push(b, f);
      @(negedge clk);
      rx_valid = 1'b0; rx_ferr = 1'b0;
   endtask

   // One AR/R transaction; optional same-cycle RX push and R-channel stall
   task automatic do_read(input logic [31:0] addr, input bit pb, input logic [7:0] pbyte,
                          input bit pferr, input int stall,
                          output logic [31:0] data_o, output logic irq_o);
      exp_t e;
      int   n;
      data_o = '0;
      irq_o  = 1'b0;
      @(negedge clk);
      araddr = addr; arvalid = 1'b1;
      if (stall > 0) rready = 1'b0;
      n = 0;
      while (!arready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ar_accept", 32'(arready), 32'd1);
      if (!arready) begin
         arvalid = 1'b0; rready = 1'b1;
         return;
      end
      if (pb) begin
         rx_byte = pbyte; rx_valid = 1'b1; rx_ferr = pferr;
      end
      exp_q.push_back(model_read(addr));
      if (pb) model_push(pbyte, pferr);
      @(negedge clk);
      arvalid = 1'b0; rx_valid = 1'b0; rx_ferr = 1'b0;
      chk("rvalid_latency", 32'(rvalid), 32'd1);
      e = exp_q.pop_front();
      if (!rvalid) begin
         rready = 1'b1;
         return;
      end
      chk("rdata", rdata, e.data);
      chk("rresp", 32'(rresp), 32'(e.resp));
      data_o = rdata;
      irq_o  = irq;
      if (stall > 0) begin
         araddr = 32'h4; arvalid = 1'b1;
         for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_rdata", rdata, e.data);
            chk("stall_rresp", 32'(rresp), 32'(e.resp));
            chk("stall_rvalid", 32'(rvalid), 32'd1);
            chk("stall_arready", 32'(arready), 32'd0);
         end
         arvalid = 1'b0;
         rready  = 1'b1;
      end
      @(negedge clk);
      chk("rvalid_drop", 32'(rvalid), 32'd0);
   endtask

   initial begin
      rst = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
      rx_byte = '0; rx_valid = 1'b0; rx_ferr = 1'b0; irq_en = 2'b00;
      m_ovf = 1'b0; m_ferr = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_arready", 32'(arready), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_arready", 32'(arready), 32'd1);
      chk("post_rst_rvalid", 32'(rvalid), 32'd0);

      do_read(32'h4, 0, 8'h0, 0, 0, got, got_irq);
      chk("reset_status", got, 32'h0);

      // Two bytes, popped in order; not-empty irq drops after the second pop
      irq_en = 2'b01;
      push_byte(8'h41, 0);
      push_byte(8'h42, 0);
      chk("irq_not_empty", 32'(irq), 32'd1);
      do_read(32'h0, 0, 8'h0, 0, 0, got, got_irq);
      chk("rx_first", got, 32'h141);
      chk("irq_after_pop1", 32'(got_irq), 32'd1);
      do_read(32'h0, 0, 8'h0, 0, 0, got, got_irq);
      chk("rx_second", got, 32'h142);
      chk("irq_after_pop2", 32'(got_irq), 32'd0);
      do_read(32'h4, 0, 8'h0, 0, 0, got, got_irq);
      chk("status_drained", got, 32'h0);

      // Overflow: 17 back-to-back bytes into a 16-deep FIFO
      irq_en = 2'b10;
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         rx_byte = 8'(8'h10 + i); rx_valid = 1'b1; rx_ferr = 1'b0;
         model_push(8'(8'h10 + i), 0);
      end
      @(negedge clk);
      rx_valid = 1'b0;
      chk("irq_overflow", 32'(irq), 32'd1);
      do_read(32'h4, 0, 8'h0, 0, 0, got, got_irq);
      chk("status_ovf", got, 32'h1007);
      chk("irq_ovf_cleared", 32'(got_irq), 32'd0);
      do_read(32'h4, 0, 8'h0, 0, 0, got, got_irq);
      chk("status_ovf_clr", got, 32'h1003);

      // Push and pop on a full FIFO: no overflow, count unchanged
      do_read(32'h0, 1, 8'h99, 0, 0, got, got_irq);
      chk("full_pop", got, 32'h110);
      do_read(32'h4, 0, 8'h0, 0, 0, got, got_irq);
      chk("full_push_pop_status", got, 32'h1003);

      // Drain: 17th byte (0x20) is absent, 0x99 arrives last
      for (int i = 0; i < 16; i++) do_read(32'h0, 0, 8'h0, 0, 0, got, got_irq);
      chk("last_after_wrap", got, 32'h199);
      do_read(32'h0, 0, 8'h0, 0, 0, got, got_irq);
      chk("empty_rxdata", got, 32'h0);

      // R-channel backpressure
      push_byte(8'h5A, 0);
      do_read(32'h0, 0, 8'h0, 0, 5, got, got_irq);
      chk("stall_read", got, 32'h15A);

      // Unmapped and misaligned offsets; upper address bits ignored
      do_read(32'h8, 0, 8'h0, 0, 0, got, got_irq);
      do_read(32'hC, 0, 8'h0, 0, 0, got, got_irq);
      do_read(32'h2, 0, 8'h0, 0, 0, got, got_irq);
      chk("misaligned_data", got, 32'h0);
      push_byte(8'h33, 0);
      do_read(32'hFFFF_FFF4, 0, 8'h0, 0, 0, got, got_irq);
      chk("upper_addr_status", got, 32'h101);
      do_read(32'hABCD_0000, 0, 8'h0, 0, 0, got, got_irq);
      chk("upper_addr_rx", got, 32'h133);

      // Push concurrent with empty RXDATA read: read empty, byte kept
      do_read(32'h0, 1, 8'h66, 0, 0, got, got_irq);
      chk("empty_read_with_push", got, 32'h0);
      do_read(32'h0, 0, 8'h0, 0, 0, got, got_irq);
      chk("byte_kept", got, 32'h166);

      // Frame error concurrent with STATUS read
      do_read(32'h4, 1, 8'h55, 1, 0, got, got_irq);
      chk("ferr_pre", got & 32'h8, 32'h0);
      do_read(32'h4, 0, 8'h0, 0, 0, got, got_irq);
      chk("ferr_post", got, 32'h109);
      do_read(32'h0, 0, 8'h0, 0, 0, got, got_irq);
      chk("ferr_rxdata", got, 32'h355);

      // Reset during RESP: beat discarded, FIFO flushed
      irq_en = 2'b01;
      push_byte(8'h77, 0);
      @(negedge clk);
      araddr = 32'h0; arvalid = 1'b1; rready = 1'b0;
      @(negedge clk);
      arvalid = 1'b0;
      chk("mid_rvalid", 32'(rvalid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
      chk("mid_rst_arready", 32'(arready), 32'd0);
      chk("mid_rst_irq", 32'(irq), 32'd0);
      rst = 1'b0; rready = 1'b1;
      mq.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
      @(negedge clk);
      chk("mid_rst_arready_back", 32'(arready), 32'd1);
      do_read(32'h4, 0, 8'h0, 0, 0, got, got_irq);
      chk("flushed_status", got, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axi_lite_uart_rd_slave.md
# axi_lite_uart_rd_slave

AXI-lite read-channel slave of the UART peripheral: accepts AR requests, decodes the register offset, and returns RX data or status on the R channel. It buffers bytes from the UART receiver (upstream deserializer) in an internal RX FIFO and drives `uart_irq`. It is the DUT-side counterpart that the bench's read driver talks to.

## Interface

- `AXI_ADDR_WIDTH`, 32, AR address width
- `AXI_DATA_WIDTH`, 32, R data width (≥16)
- `AXI_RESP_WIDTH`, 2, RRESP width
- `RX_FIFO_DEPTH`, 16, RX FIFO entries; power of 2, 2..128

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_axi_araddr`  in  AXI_ADDR_WIDTH  read address
- `s_axi_arvalid`  in  1  address valid
- `s_axi_arready`  out  1  address ready
- `s_axi_rdata`  out  AXI_DATA_WIDTH  read data
- `s_axi_rresp`  out  AXI_RESP_WIDTH  read response
- `s_axi_rvalid`  out  1  read data valid
- `s_axi_rready`  in  1  master ready for R
- `rx_byte_i`  in  8  received byte from UART receiver
- `rx_valid_i`  in  1  one-cycle strobe, byte valid
- `rx_frame_err_i`  in  1  stop-bit error for this byte, qualified by `rx_valid_i`
- `irq_en_i`  in  2  [0] RX-not-empty enable, [1] overflow enable (from write-side regs)
- `uart_irq`  out  1  registered interrupt

## Operation

- Register map on `araddr[3:0]`, upper bits ignored:
  - 0x0 RXDATA: [7:0] byte, [8] valid, [9] frame error of that byte, rest 0. Read pops FIFO when non-empty.
  - 0x4 STATUS: [0] not_empty, [1] full, [2] overflow (sticky), [3] frame_err (sticky), [15:8] count, rest 0. Read clears both sticky bits.
  - 0x8, 0xC, or `araddr[1:0]≠0`: unmapped.
- FIFO entry 9 bits {frame_err, byte}. Push on `rx_valid_i` if not full; push when full drops the byte and sets overflow. Sticky frame_err set on any push with `rx_frame_err_i`=1.
- FSM, two states:
  - IDLE: `arready`=1. On `arvalid`: register rdata/rresp, perform pop/clear, → RESP.
  - RESP: `arready`=0, `rvalid`=1, rdata/rresp held stable. On `rready`: → IDLE.
- FIFO status for a read sampled before same-cycle push.
- Simultaneous push and pop when full: both occur, no overflow, count unchanged.
- Push and RXDATA read when empty, same cycle: read returns valid=0, data 0; byte is stored.
- Sticky set and STATUS-read clear in same cycle: set wins; the returned STATUS shows pre-event value.
- `uart_irq` next = (irq_en_i[0] & not_empty) | (irq_en_i[1] & overflow).
- Count width $clog2(RX_FIFO_DEPTH)+1, zero-extended into [15:8]; pointers wrap modulo depth.

## Timing

- Reset: `arready`=0 during `rst`, 1 first cycle after; `rvalid`=0, `rdata`=0, `rresp`=0, `uart_irq`=0, FIFO empty, sticky bits 0, FSM IDLE.
- AR accepted cycle N → `rvalid` at N+1; back-to-back minimum 2 cycles per read (one transaction outstanding).
- Pop/clear take effect at end of cycle N; `uart_irq` reflects it at N+1.
- Reset mid-transaction: R beat discarded, `rvalid` low next cycle, FIFO flushed.

## Configuration

- `UART_RD_SLVERR_EN` defined: unmapped offsets and RXDATA read when empty return `rresp`=2'b10 (SLVERR), rdata 0.
- Not defined: all reads return `rresp`=2'b00 (OKAY); unmapped returns rdata 0; empty RXDATA returns 0 with valid=0.

## Structure

- Shared package `uart_pkg`: register offset constants, STATUS/RXDATA bit positions, RESP codes (OKAY, SLVERR), FSM state enum.
- One sub-module: `uart_rx_fifo` (sync FIFO, push/pop/full/empty/count, DEPTH parameter).

## Test plan

- Reset release → `arready`=1, `rvalid`=0, `uart_irq`=0; STATUS read = 0x0000_0000.
- Push 0x41, 0x42; read 0x0 twice → 0x141, 0x142; STATUS then 0x0; `irq_en_i`=01 drops `uart_irq` one cycle after second pop.
- Push 17 bytes at depth 16 → STATUS 0x1007; second STATUS read 0x1003; 17th byte lost.
- Hold `rready`=0 for 5 cycles in RESP → rdata/rresp stable, `arready`=0, second AR stalled.
- Read 0x8 and empty 0x0 → rresp 2'b10 with `UART_RD_SLVERR_EN`, 2'b00 without; rdata 0.
- Push with `rx_frame_err_i`=1 concurrent with STATUS read → STATUS shows bit3=0, next STATUS bit3=1, RXDATA 0x3xx.
